// File: rtl/sram_init_bridge_pkg.sv
// Shared types for the SRAM init bridge.
// Copy FSM states and the CPU data width.
package sram_init_bridge_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    FETCH,
    WRITE,
    RUN
  } init_state_t;

endpackage

// File: rtl/sram_init_bridge.sv
// Memory stage: copies a ROM image into on-chip RAM after reset,
// then serves SLC-3 CPU reads/writes against that RAM.
module sram_init_bridge
  import sram_init_bridge_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int INIT_WORDS = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       Data_to_SRAM,
  input  logic              OE,
  input  logic              WE,
  output logic [15:0]       Data_from_SRAM,
  output logic              Init_Done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata
);

  // One extra count bit so a full-depth image never wraps to 0.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(INIT_WORDS - 1);

  init_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic rd_ok_q, rd_ok_d;
  logic in_range;

  generate
    if (ADDR_W >= DATA_W) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = (ADDR[DATA_W-1:ADDR_W] == '0);
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    rd_ok_d   = 1'b0;
    ram_addr  = cnt_q[ADDR_W-1:0];
    ram_wdata = rom_data;
    ram_we    = 1'b0;
    unique case (state_q)
      FETCH: begin
        state_d = WRITE;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = FETCH;
        end
      end
      RUN: begin
        ram_addr  = ADDR[ADDR_W-1:0];
        ram_wdata = Data_to_SRAM;
        ram_we    = ~WE & in_range;
        rd_ok_d   = ~OE & in_range;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign rom_addr       = cnt_q[ADDR_W-1:0];
  assign Init_Done      = done_q;
  assign Data_from_SRAM = rd_ok_q ? ram_rdata : 16'h0000;

endmodule
